up_dp_param: RTL and testbench

UP_DP_PARAM -- requirements
Module: up_dp_param

---
 rtl/up_dp_pkg.sv | 21 ++
 rtl/up_alu.sv | 42 ++++
 rtl/up_dp_param.sv | 103 ++++++++++
 tb/tb_up_dp_param.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/up_dp_pkg.sv
// Shared encodings and default widths for the accumulator datapath.
package up_dp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ASEL_ALU   = 2'b00,
    ASEL_INPUT = 2'b01,
    ASEL_MEM   = 2'b10,
    ASEL_IMM   = 2'b11
  } aSel_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } aluOp_e;

endpackage

// File: rtl/up_alu.sv
// Combinational ALU: A op MemOutput with carry/borrow and signed overflow.
module up_alu
  import up_dp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  aluOp_e            op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              ovf
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      ALU_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        ovf    = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
        ovf    = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/up_dp_param.sv
// Accumulator datapath: PC, IR, A register, async-read memory and ALU flags.
module up_dp_param
  import up_dp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic [DATA_W-1:0]        Input,
  input  logic                     IRload,
  input  logic                     JMPmux,
  input  logic                     PCload,
  input  logic                     Meminst,
  input  logic                     MemWr,
  input  logic                     Aload,
  input  logic [1:0]               Asel,
  input  logic [1:0]               AluOp,
  output logic                     Aeq0,
  output logic                     Apos,
  output logic                     Carry,
  output logic                     Ovf,
  output logic [DATA_W-ADDR_W-1:0] IR,
  output logic [DATA_W-1:0]        Output,
  output logic [DATA_W-1:0]        MemOutput,
  output logic [ADDR_W-1:0]        AddOutput
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] pcReg;
  logic [DATA_W-1:0] irReg;
  logic [DATA_W-1:0] accReg;
  logic              carryReg;
  logic              ovfReg;

  logic [ADDR_W-1:0] irAddr;
  logic [DATA_W-1:0] accNext;
  logic [DATA_W-1:0] aluResult;
  logic              aluCarry;
  logic              aluOvf;
  logic              flagUpdate;

  assign irAddr    = irReg[ADDR_W-1:0];
  assign AddOutput = Meminst ? irAddr : pcReg;
  assign MemOutput = mem[AddOutput];

  up_alu #(
    .DATA_W (DATA_W)
  ) uAlu (
    .a      (accReg),
    .b      (MemOutput),
    .op     (aluOp_e'(AluOp)),
    .result (aluResult),
    .carry  (aluCarry),
    .ovf    (aluOvf)
  );

  always_comb begin
    accNext = aluResult;
    case (aSel_e'(Asel))
      ASEL_ALU:   accNext = aluResult;
      ASEL_INPUT: accNext = Input;
      ASEL_MEM:   accNext = MemOutput;
      ASEL_IMM:   accNext = {{(DATA_W-ADDR_W){1'b0}}, irAddr};
      default:    accNext = aluResult;
    endcase
  end

  // Flags only follow arithmetic results that actually land in A.
  assign flagUpdate = Aload && (aSel_e'(Asel) == ASEL_ALU) &&
                      ((aluOp_e'(AluOp) == ALU_ADD) || (aluOp_e'(AluOp) == ALU_SUB));

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pcReg    <= '0;
      irReg    <= '0;
      accReg   <= '0;
      carryReg <= 1'b0;
      ovfReg   <= 1'b0;
    end else begin
      if (PCload) pcReg <= JMPmux ? irAddr : pcReg + 1'b1;
      if (IRload) irReg <= MemOutput;
      if (Aload) accReg <= accNext;
      if (flagUpdate) begin
        carryReg <= aluCarry;
        ovfReg   <= aluOvf;
      end
    end
  end

  // Memory is never cleared; writes are only blocked while reset is held.
  always_ff @(posedge CLOCK) begin
    if (MemWr && !RESET) mem[AddOutput] <= accReg;
  end

  assign Output = accReg;
  assign IR     = irReg[DATA_W-1:ADDR_W];
  assign Carry  = carryReg;
  assign Ovf    = ovfReg;
  assign Aeq0   = (accReg == '0);
  assign Apos   = ~accReg[DATA_W-1];

endmodule

// File: tb/tb_up_dp_param.sv
// Directed bench for up_dp_param with a queue-based scoreboard and monitor.
module tb_up_dp_param;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [7:0] Input;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload;
  logic [1:0] Asel, AluOp;
  logic       Aeq0, Apos, Carry, Ovf;
  logic [2:0] IR;
  logic [7:0] Output, MemOutput;
  logic [4:0] AddOutput;

  up_dp_param #(.DATA_W(8), .ADDR_W(5)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .Input     (Input),
    .IRload    (IRload),
    .JMPmux    (JMPmux),
    .PCload    (PCload),
    .Meminst   (Meminst),
    .MemWr     (MemWr),
    .Aload     (Aload),
    .Asel      (Asel),
    .AluOp     (AluOp),
    .Aeq0      (Aeq0),
    .Apos      (Apos),
    .Carry     (Carry),
    .Ovf       (Ovf),
    .IR        (IR),
    .Output    (Output),
    .MemOutput (MemOutput),
    .AddOutput (AddOutput)
  );

  always #5 CLOCK = ~CLOCK;

  typedef enum int {K_OUT, K_ADDR, K_MEM, K_IR, K_AEQ0, K_APOS, K_CARRY, K_OVF} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  exp_t sbQ[$];
  event sampleEv;
  int   compared   = 0;
  int   mismatched = 0;

  // Monitor: drains every pending expectation each time the outputs are presented.
  always begin
    @(sampleEv);
    while (sbQ.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sbQ.pop_front();
      case (e.kind)
        K_OUT:   act = {24'd0, Output};
        K_ADDR:  act = {27'd0, AddOutput};
        K_MEM:   act = {24'd0, MemOutput};
        K_IR:    act = {29'd0, IR};
        K_AEQ0:  act = {31'd0, Aeq0};
        K_APOS:  act = {31'd0, Apos};
        K_CARRY: act = {31'd0, Carry};
        default: act = {31'd0, Ovf};
      endcase
      compared++;
      if (act !== e.val) begin
        mismatched++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
      end else begin
        $display("ok   %s = 0x%0h", e.name, act);
      end
    end
  end

  task automatic idle();
    Input = 8'h00; IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0;
    MemWr = 0; Aload = 0; Asel = 2'b00; AluOp = 2'b00;
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
    idle();
    #1;
  endtask

  task automatic expect_v(input string name, input kind_e kind, input logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.val = val;
    sbQ.push_back(e);
  endtask

  task automatic fire();
    ->sampleEv;
    #1;
  endtask

  task automatic loadInput(input logic [7:0] v);
    Input = v; Asel = 2'b01; Aload = 1;
    step();
  endtask

  task automatic aluOp(input logic [1:0] op);
    Asel = 2'b00; AluOp = op; Aload = 1;
    step();
  endtask

  initial begin
    idle();
    RESET = 1; MemWr = 1;
    step();
    RESET = 1; MemWr = 1;
    step();
    RESET = 0;
    expect_v("rst_out", K_OUT, 0);
    expect_v("rst_addr", K_ADDR, 0);
    expect_v("rst_ir", K_IR, 0);
    expect_v("rst_aeq0", K_AEQ0, 1);
    expect_v("rst_apos", K_APOS, 1);
    expect_v("rst_carry", K_CARRY, 0);
    expect_v("rst_ovf", K_OVF, 0);
    fire();

    // Reset must block a concurrent write and leave memory intact.
    loadInput(8'h77);
    MemWr = 1; step();
    loadInput(8'h11);
    RESET = 1; MemWr = 1; step();
    RESET = 0;
    expect_v("rst_nowrite_mem0", K_MEM, 8'h77);
    expect_v("rst_nowrite_out", K_OUT, 0);
    fire();

    // Input / store
    loadInput(8'h5A);
    expect_v("in_out", K_OUT, 8'h5A);
    expect_v("in_aeq0", K_AEQ0, 0);
    expect_v("in_apos", K_APOS, 1);
    fire();
    MemWr = 1; PCload = 1; JMPmux = 0;
    #1;
    expect_v("store_old_word", K_MEM, 8'h77);
    fire();
    step();
    expect_v("store_pc_inc", K_ADDR, 1);
    fire();
    Meminst = 1;
    #1;
    expect_v("store_mem0", K_MEM, 8'h5A);
    fire();
    idle();

    // Add with carry: 0xF0 + 0x20 at mem[1]
    loadInput(8'h20);
    MemWr = 1; step();
    loadInput(8'hF0);
    aluOp(2'b00);
    expect_v("add1_out", K_OUT, 8'h10);
    expect_v("add1_carry", K_CARRY, 1);
    expect_v("add1_ovf", K_OVF, 0);
    fire();

    // Add with signed overflow: 0x7F + 0x01 at mem[2]
    PCload = 1; step();
    loadInput(8'h01);
    MemWr = 1; step();
    loadInput(8'h7F);
    aluOp(2'b00);
    expect_v("add2_out", K_OUT, 8'h80);
    expect_v("add2_carry", K_CARRY, 0);
    expect_v("add2_ovf", K_OVF, 1);
    expect_v("add2_apos", K_APOS, 0);
    fire();

    // Logic ops leave the flags alone
    aluOp(2'b10);
    expect_v("and_out", K_OUT, 8'h00);
    expect_v("and_aeq0", K_AEQ0, 1);
    expect_v("and_ovf_hold", K_OVF, 1);
    expect_v("and_carry_hold", K_CARRY, 0);
    fire();
    aluOp(2'b11);
    expect_v("or_out", K_OUT, 8'h01);
    fire();

    // Subtract with borrow: 0x03 - 0x05 at mem[3]
    PCload = 1; step();
    loadInput(8'h05);
    MemWr = 1; step();
    loadInput(8'h03);
    aluOp(2'b01);
    expect_v("sub_out", K_OUT, 8'hFE);
    expect_v("sub_carry", K_CARRY, 1);
    expect_v("sub_ovf", K_OVF, 0);
    expect_v("sub_aeq0", K_AEQ0, 0);
    fire();

    // Jump: put 0xE3 at mem[0] via the IR address field (IR is still 0)
    loadInput(8'hE3);
    MemWr = 1; Meminst = 1; step();
    Meminst = 1; IRload = 1; PCload = 1; JMPmux = 0; step();
    expect_v("jmp_ir_op", K_IR, 3'b111);
    expect_v("jmp_pc_inc", K_ADDR, 4);
    fire();
    PCload = 1; JMPmux = 1; step();
    expect_v("jmp_target", K_ADDR, 3);
    fire();
    Asel = 2'b11; Aload = 1; step();
    expect_v("imm_load", K_OUT, 8'h03);
    fire();

    // Same-edge IR and PC update: the jump uses the old IR field (3)
    IRload = 1; PCload = 1; JMPmux = 1; step();
    expect_v("pre_edge_pc", K_ADDR, 3);
    expect_v("pre_edge_ir", K_IR, 0);
    fire();

    // Wrap: jump to 31 then increment
    loadInput(8'h1F);
    MemWr = 1; step();
    IRload = 1; step();
    PCload = 1; JMPmux = 1; step();
    expect_v("pc_31", K_ADDR, 31);
    fire();
    PCload = 1; JMPmux = 0; step();
    expect_v("pc_wrap", K_ADDR, 0);
    expect_v("wrap_mem0", K_MEM, 8'hE3);
    fire();

    begin
      int waitCnt = 0;
      while (sbQ.size() > 0 && waitCnt < 100) begin
        #1;
        waitCnt++;
      end
      if (sbQ.size() > 0) begin
        mismatched++;
        $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbQ.size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
